// File: rtl/key_note_sequencer_if.sv
// Control and status bundle between the piano front end and the key/note sequencer.
// The sequencer sits on the slave side; the front end (or a bench) drives the master side.
interface key_note_sequencer_if #(
  parameter int NUM_KEYS = 48,
  parameter int IDX_W    = 6,
  parameter int ADDR_W   = 9
);
  logic [NUM_KEYS-1:0] keys;
  logic                rec_start;
  logic                play_start;
  logic                stop;
  logic                loop_en;
  logic [IDX_W-1:0]    note_idx;
  logic                playing;
  logic                recording;
  logic [ADDR_W-1:0]   beat_num;
  logic [ADDR_W:0]     rec_len;
  logic                done;

  modport master (
    output keys, rec_start, play_start, stop, loop_en,
    input  note_idx, playing, recording, beat_num, rec_len, done
  );

  modport slave (
    input  keys, rec_start, play_start, stop, loop_en,
    output note_idx, playing, recording, beat_num, rec_len, done
  );
endinterface

// File: rtl/key_note_sequencer.sv
// Live key encoder plus beat-quantised note recorder/player.
// One note index is stored per beat and replayed once or looping.
module key_note_sequencer #(
  parameter int NUM_KEYS    = 48,
  parameter int DEPTH       = 512,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int IDX_W       = 6,
  parameter int ADDR_W      = 9
) (
  input logic                 clk,
  input logic                 reset,
  key_note_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(BEAT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_KEYS-1:0] keys_q;
  logic [IDX_W-1:0]    live_idx;
  logic [IDX_W-1:0]    rd_data;
  logic [IDX_W-1:0]    note_q;
  logic                play_d;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W:0]     rec_len_q;
  logic                done_q;
  logic                tick;
  logic                wr_en;
  logic                last_slot;
  logic [IDX_W-1:0]    mem [DEPTH];

  // Lowest set key wins; no key pressed encodes as the rest index NUM_KEYS.
  function automatic logic [IDX_W-1:0] encode(input logic [NUM_KEYS-1:0] k);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(NUM_KEYS);
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (k[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign tick      = (state != IDLE) && (cnt == CNT_W'(BEAT_CYCLES - 1));
  // A beat that ends together with a stop or restart command is discarded.
  assign wr_en     = (state == RECORD) && tick && !bus.stop && !bus.rec_start;
  assign last_slot = ({1'b0, ptr} == (rec_len_q - (ADDR_W + 1)'(1)));

  // Input register, encoder register and output mux; play_d delays the
  // live/playback switch so it lines up with the one-cycle RAM read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keys_q   <= '0;
      live_idx <= IDX_W'(NUM_KEYS);
      play_d   <= 1'b0;
      note_q   <= IDX_W'(NUM_KEYS);
    end else begin
      keys_q   <= bus.keys;
      live_idx <= encode(keys_q);
      play_d   <= (state == PLAY);
      note_q   <= play_d ? rd_data : encode(keys_q);
    end
  end

  // Note memory: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= live_idx;
    rd_data <= mem[ptr];
  end

  // Sequencer FSM with beat counter, slot pointer and recording length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      rec_len_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        if (state == RECORD) rec_len_q <= {1'b0, ptr};
        else                 rec_len_q <= rec_len_q;
        state <= IDLE;
        cnt   <= '0;
        ptr   <= '0;
      end else if (bus.rec_start) begin
        state     <= RECORD;
        cnt       <= '0;
        ptr       <= '0;
        rec_len_q <= '0;
      end else if (bus.play_start && (state != RECORD) && (rec_len_q != '0)) begin
        state <= PLAY;
        cnt   <= '0;
        ptr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            ptr <= '0;
          end
          RECORD: begin
            if (tick) begin
              cnt <= '0;
              if (ptr == ADDR_W'(DEPTH - 1)) begin
                rec_len_q <= (ADDR_W + 1)'(DEPTH);
                state     <= IDLE;
                ptr       <= '0;
              end else begin
                ptr <= ptr + ADDR_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PLAY: begin
            if (tick) begin
              cnt <= '0;
              if (last_slot) begin
                ptr <= '0;
                if (!bus.loop_en) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                end else begin
                  state <= PLAY;
                end
              end else begin
                ptr <= ptr + ADDR_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.note_idx  = note_q;
  assign bus.playing   = (state == PLAY);
  assign bus.recording = (state == RECORD);
  assign bus.beat_num  = ptr;
  assign bus.rec_len   = rec_len_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_key_note_sequencer.sv
// Directed bench for key_note_sequencer with 48 keys, 8 slots and 4-cycle beats.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_note_sequencer;

  localparam int NK = 48;
  localparam int LIVE_REST = 48;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  int   base;

  key_note_sequencer_if #(.NUM_KEYS(NK), .IDX_W(6), .ADDR_W(3)) bus ();

  key_note_sequencer #(
    .NUM_KEYS(NK), .DEPTH(8), .BEAT_CYCLES(4), .IDX_W(6), .ADDR_W(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count done pulses shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (bus.done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NK-1:0] key_of(input int n);
    logic [NK-1:0] one;
    one = {{(NK-1){1'b0}}, 1'b1};
    if (n >= NK) return '0;
    else         return one << n;
  endfunction

  // which: 0 = rec_start, 1 = play_start, 2 = stop; held for one cycle.
  task automatic pulse(input int which);
    case (which)
      0:       bus.rec_start  = 1'b1;
      1:       bus.play_start = 1'b1;
      default: bus.stop       = 1'b1;
    endcase
    @(negedge clk);
    bus.rec_start  = 1'b0;
    bus.play_start = 1'b0;
    bus.stop       = 1'b0;
  endtask

  // Entered one cycle after rec_start; one key per beat.
  task automatic record(input int n, input int notes[8]);
    for (int k = 0; k < n; k++) begin
      check("rec_beat_num", 32'(bus.beat_num), k);
      check("rec_recording", 32'(bus.recording), 32'd1);
      bus.keys = key_of(notes[k]);
      wait_neg(4);
    end
  endtask

  // Entered one cycle after play_start; each slot shows 3..6 cycles after its pointer update.
  task automatic play_pass(input int n, input int notes[8], input bit once, input int live);
    check("play_on", 32'(bus.playing), 32'd1);
    check("play_beat0", 32'(bus.beat_num), 32'd0);
    wait_neg(1);
    check("play_live_before", 32'(bus.note_idx), live);
    wait_neg(1);
    for (int k = 0; k < n; k++) begin
      check("play_note", 32'(bus.note_idx), notes[k]);
      check("play_beat", 32'(bus.beat_num), k);
      if (once && k == n - 1) begin
        wait_neg(2);
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_playing", 32'(bus.playing), 32'd0);
        wait_neg(1);
        check("done_clear", 32'(bus.done), 32'd0);
        check("tail_note", 32'(bus.note_idx), notes[k]);
        wait_neg(1);
        check("back_live", 32'(bus.note_idx), live);
      end else begin
        wait_neg(3);
        check("play_hold", 32'(bus.note_idx), notes[k]);
        wait_neg(1);
      end
    end
  endtask

  int seq8[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
  int seq3[8]  = '{5, 48, 9, 0, 0, 0, 0, 0};

  initial begin
    reset = 1'b0;
    bus.keys = '0;
    bus.rec_start = 1'b0;
    bus.play_start = 1'b0;
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    wait_neg(3);
    check("rst_note", 32'(bus.note_idx), LIVE_REST);
    check("rst_playing", 32'(bus.playing), 32'd0);
    check("rst_recording", 32'(bus.recording), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_beat", 32'(bus.beat_num), 32'd0);
    check("rst_len", 32'(bus.rec_len), 32'd0);
    reset = 1'b1;
    wait_neg(1);

    // Live encoder latency and priority.
    bus.keys = 48'h0000_0000_0210;
    wait_neg(1);
    check("live_lat1", 32'(bus.note_idx), LIVE_REST);
    wait_neg(1);
    check("live_0x210", 32'(bus.note_idx), 32'd4);
    bus.keys = '0;
    wait_neg(2);
    check("live_none", 32'(bus.note_idx), LIVE_REST);
    bus.keys = key_of(47);
    wait_neg(2);
    check("live_47", 32'(bus.note_idx), 32'd47);
    bus.keys = '0;

    // Playback with nothing recorded is ignored.
    pulse(1);
    check("empty_play", 32'(bus.playing), 32'd0);
    wait_neg(2);
    check("empty_play_idle", 32'(bus.playing), 32'd0);

    // rec_start beats play_start; fill all 8 slots.
    bus.rec_start = 1'b1;
    bus.play_start = 1'b1;
    wait_neg(1);
    bus.rec_start = 1'b0;
    bus.play_start = 1'b0;
    check("both_cmd_rec", 32'(bus.recording), 32'd1);
    check("both_cmd_play", 32'(bus.playing), 32'd0);
    record(8, seq8);
    check("full_exit", 32'(bus.recording), 32'd0);
    check("full_len", 32'(bus.rec_len), 32'd8);
    check("full_beat", 32'(bus.beat_num), 32'd0);
    bus.keys = '0;
    wait_neg(2);
    base = done_cnt;
    pulse(1);
    play_pass(8, seq8, 1'b1, LIVE_REST);
    check("full_done_cnt", done_cnt - base, 32'd1);

    // Stop after three beats, then play once.
    pulse(0);
    record(3, seq3);
    pulse(2);
    check("stop_rec_off", 32'(bus.recording), 32'd0);
    check("stop_len", 32'(bus.rec_len), 32'd3);
    bus.keys = key_of(20);
    wait_neg(3);
    base = done_cnt;
    pulse(1);
    play_pass(3, seq3, 1'b1, 20);
    check("once_done_cnt", done_cnt - base, 32'd1);

    // Looping playback, stopped during the second pass.
    bus.loop_en = 1'b1;
    base = done_cnt;
    pulse(1);
    play_pass(3, seq3, 1'b0, 20);
    check("loop_still_on", 32'(bus.playing), 32'd1);
    check("loop_p2_note0", 32'(bus.note_idx), 32'd5);
    wait_neg(4);
    check("loop_p2_note1", 32'(bus.note_idx), 32'd48);
    pulse(2);
    check("loop_stop_off", 32'(bus.playing), 32'd0);
    check("loop_stop_beat", 32'(bus.beat_num), 32'd0);
    wait_neg(3);
    check("loop_no_done", done_cnt - base, 32'd0);
    check("loop_len_kept", 32'(bus.rec_len), 32'd3);
    bus.loop_en = 1'b0;

    // Stop arriving with the second beat's tick keeps only the first beat.
    pulse(0);
    bus.keys = key_of(7);
    wait_neg(7);
    pulse(2);
    check("stoptick_off", 32'(bus.recording), 32'd0);
    check("stoptick_len", 32'(bus.rec_len), 32'd1);

    // Asynchronous reset in the middle of playback.
    pulse(1);
    check("arst_pre_play", 32'(bus.playing), 32'd1);
    wait_neg(1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_playing", 32'(bus.playing), 32'd0);
    check("arst_len", 32'(bus.rec_len), 32'd0);
    check("arst_beat", 32'(bus.beat_num), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_neg(1);
    pulse(1);
    check("arst_play_ign", 32'(bus.playing), 32'd0);
    wait_neg(2);
    check("arst_still_idle", 32'(bus.playing), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_note_sequencer.md
# key_note_sequencer

Parametrised live-key encoder and beat-quantised note recorder/player for the piano datapath. Resolves the pressed-key vector to a single note index, records one index per beat into internal memory, and replays it once or looping. The note index feeds the downstream frequency table, PWM tone generator, and VGA key highlight. It generalises the fixed 48-key / fixed-beat record path with parametrised key count, depth, beat length, loop mode, and explicit stop.

## Interface

- NUM_KEYS, 48, number of key inputs; index NUM_KEYS means "no key / rest".
- DEPTH, 512, recording slots (one per beat).
- BEAT_CYCLES, 12_500_000, clk cycles per beat (≥2).
- IDX_W, 6, note index width; must satisfy 2^IDX_W > NUM_KEYS.
- ADDR_W, 9, slot address width; must satisfy 2^ADDR_W ≥ DEPTH.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- keys  in  NUM_KEYS  pressed keys, level; bit 0 is highest priority.
- rec_start  in  1  single-cycle pulse; begin recording.
- play_start  in  1  single-cycle pulse; begin playback.
- stop  in  1  single-cycle pulse; end record/play.
- loop_en  in  1  level; sampled at each end of playback.
- note_idx  out  IDX_W  current note (live or played back); NUM_KEYS = rest.
- playing  out  1  high in PLAY state.
- recording  out  1  high in RECORD state.
- beat_num  out  ADDR_W  current slot pointer (write pointer in RECORD, read pointer in PLAY, 0 in IDLE).
- rec_len  out  ADDR_W+1  number of valid recorded slots.
- done  out  1  one-cycle pulse when playback ends without looping.

## Operation

- Encoder: the lowest set bit of keys gives index i. If keys == 0, the index is NUM_KEYS.
- FSM states are IDLE, RECORD, PLAY. Reset state is IDLE.
- Command priority in the same cycle: stop > rec_start > play_start.
- IDLE:
  - note_idx = registered live index.
  - rec_start: go to RECORD; write pointer = 0; beat counter = 0.
  - play_start with rec_len > 0: go to PLAY; read pointer = 0; beat counter = 0.
  - play_start with rec_len == 0: ignored.
  - stop: no effect.
- Beat counter:
  - Counts 0..BEAT_CYCLES-1 in RECORD and PLAY.
  - tick = counter == BEAT_CYCLES-1. The counter wraps to 0 on tick.
  - Held at 0 in IDLE.
- RECORD:
  - note_idx stays live.
  - On tick: mem[wr_ptr] ← live index, wr_ptr++.
  - When the write lands in slot DEPTH-1: rec_len = DEPTH, go to IDLE.
  - On stop: rec_len = wr_ptr (slots written so far, may be 0), go to IDLE. A tick in the same cycle as stop is discarded.
  - rec_start while already in RECORD: restart at wr_ptr = 0.
  - Previous contents are invalid from RECORD entry onward.
- PLAY:
  - note_idx = mem[rd_ptr].
  - On tick with rd_ptr < rec_len-1: rd_ptr++.
  - On tick with rd_ptr == rec_len-1:
    - loop_en = 1: rd_ptr = 0, stay in PLAY.
    - loop_en = 0: go to IDLE and pulse done.
  - On stop: go to IDLE, no done pulse.
  - play_start while in PLAY: restart at rd_ptr = 0.
  - rec_start while in PLAY: go to RECORD.
- Memory: DEPTH × IDX_W, synchronous write, synchronous read; must infer block RAM.
- Reset mid-operation: return to IDLE immediately. Counters, pointers and rec_len clear to 0. Memory contents are not cleared, but are unreachable because rec_len = 0.

## Timing

- Reset values:
  - note_idx = NUM_KEYS.
  - playing, recording, done = 0.
  - beat_num = 0, rec_len = 0.
- Live path: a keys change appears on note_idx 2 cycles later (input register + encoder register).
- Command latency: playing/recording assert the cycle after the command pulse; beat counter = 0 in that cycle.
- First RECORD tick occurs BEAT_CYCLES cycles after recording rises. The write samples the live index registered at the tick cycle.
- PLAY read latency: note_idx = mem[rd_ptr] 2 cycles after rd_ptr changes (RAM read + output register). This includes the first slot after PLAY entry.
- done is asserted in the same cycle playing falls. note_idx returns to live 2 cycles later.
- beat_num updates the cycle after a tick.

## Test plan

- Reset/live encode: hold reset low, then release; apply keys = 0x000000000210 → note_idx = 4 two cycles later; keys = 0 → 48; keys[47] only → 47.
- Record full: BEAT_CYCLES = 4, DEPTH = 8; rec_start, step keys through indices 0..7, one per beat → auto-exit after 8 ticks (32 cycles + 1), rec_len = 8, mem holds 0..7.
- Stop mid-record, then play once: record 3 beats (5, 48, 9), pulse stop → rec_len = 3; play_start with loop_en = 0 → note_idx sequence 5, 48, 9, each held 4 cycles, then done pulses once and playing = 0.
- Loop and stop: same recording, loop_en = 1 → note_idx sequence 5, 48, 9, 5, 48, 9...; stop during the 2nd pass → IDLE, no done pulse.
- Edge commands: play_start with rec_len = 0 → stays IDLE; rec_start + play_start in the same cycle → RECORD; stop + tick in the same cycle during RECORD → rec_len excludes that beat.
- Async reset during PLAY: drive reset low between clock edges → playing = 0 and rec_len = 0 immediately; subsequent play_start is ignored.
